// File: rtl/issue_scoreboard_if.sv
// Issue-stage handshake bundle between decode and the issue scoreboard.
interface issue_scoreboard_if #(
    parameter int unsigned NREG = 32
);
    localparam int unsigned RW = $clog2(NREG);

    logic            issue_valid_i;
    logic [1:0]      issue_unit_i;
    logic [RW-1:0]   issue_rs1_i;
    logic            issue_rs1_use_i;
    logic [RW-1:0]   issue_rs2_i;
    logic            issue_rs2_use_i;
    logic [RW-1:0]   issue_rd_i;
    logic            issue_rd_wr_i;
    logic            mem_miss_i;
    logic            issue_fire_o;
    logic            stall_core_o;
    logic [2:0]      stall_cause_o;
    logic [NREG-1:0] pending_mask_o;

    modport master (
        output issue_valid_i, issue_unit_i, issue_rs1_i, issue_rs1_use_i,
               issue_rs2_i, issue_rs2_use_i, issue_rd_i, issue_rd_wr_i, mem_miss_i,
        input  issue_fire_o, stall_core_o, stall_cause_o, pending_mask_o
    );

    modport slave (
        input  issue_valid_i, issue_unit_i, issue_rs1_i, issue_rs1_use_i,
               issue_rs2_i, issue_rs2_use_i, issue_rd_i, issue_rd_wr_i, mem_miss_i,
        output issue_fire_o, stall_core_o, stall_cause_o, pending_mask_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: RAW / WAW / write-back-port hazard detection for ALU, MUL and LOAD ops.
// Freezes all tracking state while the cache stage reports a miss.
module issue_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned MUL_LAT = 5
) (
    input logic              clk_i,
    input logic              rsn_i,
    issue_scoreboard_if.slave sb
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        UNIT_ALU  = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_LOAD = 2'd2,
        UNIT_NONE = 2'd3
    } unit_e;

    logic [CW-1:0]      cnt_q [NREG];
    logic [CW-1:0]      cnt_d [NREG];
    logic [MUL_LAT-1:0] wb_slot_q;
    logic [MUL_LAT-1:0] wb_slot_d;
    logic [MUL_LAT-1:0] wb_slot_shift;

    logic          wr_track;
    logic [CW-1:0] lat_m1;
    logic          raw;
    logic          waw;
    logic          strct;
    logic          stall;
    logic          fire;
    logic [NREG-1:0] pend;

    // Latency minus one: the count a freshly issued write starts from.
    always_comb begin
        lat_m1 = '0;
        case (unit_e'(sb.issue_unit_i))
            UNIT_ALU:  lat_m1 = CW'(ALU_LAT - 1);
            UNIT_MUL:  lat_m1 = CW'(MUL_LAT - 1);
            UNIT_LOAD: lat_m1 = CW'(MEM_LAT - 1);
            default:   lat_m1 = '0;
        endcase
    end

    // Hazard detection; the port-conflict check looks at the reservation vector as it
    // stands after this edge's shift, so back-to-back ALU writes do not collide.
    always_comb begin
        wr_track = sb.issue_rd_wr_i && (sb.issue_rd_i != RW'(0))
                   && (unit_e'(sb.issue_unit_i) != UNIT_NONE);
        raw = (sb.issue_rs1_use_i && (sb.issue_rs1_i != RW'(0)) && (cnt_q[sb.issue_rs1_i] != '0))
           || (sb.issue_rs2_use_i && (sb.issue_rs2_i != RW'(0)) && (cnt_q[sb.issue_rs2_i] != '0));
        waw = wr_track && (cnt_q[sb.issue_rd_i] > lat_m1);
        wb_slot_shift = sb.mem_miss_i ? wb_slot_q : (wb_slot_q >> 1);
        strct = wr_track && wb_slot_shift[lat_m1];
        stall = sb.mem_miss_i | (sb.issue_valid_i & (raw | waw | strct));
        fire  = sb.issue_valid_i & ~stall;
    end

    // Next state: age all counters unless frozen, then book the accepted write.
    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            cnt_d[r] = cnt_q[r];
            if (!sb.mem_miss_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
        wb_slot_d = wb_slot_shift;
        if (fire && wr_track) begin
            cnt_d[sb.issue_rd_i] = lat_m1;
            wb_slot_d = wb_slot_shift | (MUL_LAT'(1) << lat_m1);
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            pend[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= '0;
            end
            wb_slot_q <= '0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wb_slot_q <= wb_slot_d;
        end
    end

    assign sb.stall_core_o   = stall;
    assign sb.issue_fire_o   = fire;
    assign sb.stall_cause_o  = (stall && !sb.mem_miss_i) ? {strct, waw, raw} : 3'b000;
    assign sb.pending_mask_o = pend;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected outputs queued with each stimulus step, checked at negedge.
module tb_issue_scoreboard;
    logic clk;
    logic rsn;

    issue_scoreboard_if #(.NREG(32)) bus ();

    issue_scoreboard #(
        .NREG(32), .ALU_LAT(1), .MEM_LAT(2), .MUL_LAT(5)
    ) dut (
        .clk_i(clk),
        .rsn_i(rsn),
        .sb   (bus)
    );

    typedef struct packed {
        logic        fire;
        logic        stall;
        logic [2:0]  cause;
        logic [31:0] mask;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] u, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic w,
                         input logic miss);
        bus.issue_valid_i   = v;
        bus.issue_unit_i    = u;
        bus.issue_rs1_i     = r1;
        bus.issue_rs1_use_i = u1;
        bus.issue_rs2_i     = r2;
        bus.issue_rs2_use_i = u2;
        bus.issue_rd_i      = rd;
        bus.issue_rd_wr_i   = w;
        bus.mem_miss_i      = miss;
    endtask

    task automatic push(input logic ef, input logic es, input logic [2:0] ec, input logic [31:0] em);
        exp_t e;
        e.fire = ef; e.stall = es; e.cause = ec; e.mask = em;
        q.push_back(e);
    endtask

    // Sample at negedge, then advance to just after the next rising edge.
    task automatic check(input string tag);
        exp_t e;
        @(negedge clk);
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s queue empty obs=0 exp=1", tag);
        end else begin
            e = q.pop_front();
            total++;
            assert (bus.issue_fire_o === e.fire) else begin
                bad++; $error("FAIL %s.fire obs=%b exp=%b", tag, bus.issue_fire_o, e.fire);
            end
            total++;
            assert (bus.stall_core_o === e.stall) else begin
                bad++; $error("FAIL %s.stall obs=%b exp=%b", tag, bus.stall_core_o, e.stall);
            end
            total++;
            assert (bus.stall_cause_o === e.cause) else begin
                bad++; $error("FAIL %s.cause obs=%b exp=%b", tag, bus.stall_cause_o, e.cause);
            end
            total++;
            assert (bus.pending_mask_o === e.mask) else begin
                bad++; $error("FAIL %s.mask obs=%h exp=%h", tag, bus.pending_mask_o, e.mask);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [1:0] u, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic w,
                       input logic miss, input logic ef, input logic es, input logic [2:0] ec,
                       input logic [31:0] em, input string tag);
        drive(v, u, r1, u1, r2, u2, rd, w, miss);
        push(ef, es, ec, em);
        check(tag);
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, "drain");
    endtask

    initial begin
        rsn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, "reset");
        rsn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, "idle");

        // MUL x5 then dependent ADD x6<-x5; at t4 the write-back port is also taken
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 3'b000, 32'h0, "s1_mul");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b001, 32'h20, "s1_raw");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b101, 32'h20, "s1_raw_struct");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 1, 0, 3'b000, 32'h0, "s1_fire");
        drain();

        // ALU back-to-back
        cyc(1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 3'b000, 32'h0, "s2_add0");
        cyc(1, 0, 3, 1, 3, 1, 4, 1, 0, 1, 0, 3'b000, 32'h0, "s2_b2b");
        drain();

        // Independent ADD collides with MUL on the write-back port at t4
        cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 3'b000, 32'h0, "s3_mul");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h80, "s3_wait");
        cyc(1, 0, 0, 0, 0, 0, 8, 1, 0, 0, 1, 3'b100, 32'h80, "s3_struct");
        cyc(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 3'b000, 32'h0, "s3_fire");
        drain();

        // WAW on x9; at t4 the older write is still one cycle out and the port is taken
        cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 3'b000, 32'h0, "s4_mul");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 3'b010, 32'h200, "s4_waw");
        cyc(1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 3'b110, 32'h200, "s4_waw_struct");
        cyc(1, 0, 0, 0, 0, 0, 9, 1, 0, 1, 0, 3'b000, 32'h0, "s4_fire");
        drain();

        // Miss freezes the countdown for three cycles
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 3'b000, 32'h0, "s5_mul");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b001, 32'h20, "s5_raw");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 5, 1, 0, 0, 6, 1, 1, 0, 1, 3'b000, 32'h20, "s5_miss");
        for (int i = 0; i < 2; i++)
            cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b001, 32'h20, "s5_raw_after");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b101, 32'h20, "s5_raw_struct");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 1, 0, 3'b000, 32'h0, "s5_fire");
        drain();

        // LOAD then dependent via rs2; LOAD data and the ADD would share a write-back cycle
        cyc(1, 2, 0, 0, 0, 0, 10, 1, 0, 1, 0, 3'b000, 32'h0, "s6_load");
        cyc(1, 0, 0, 0, 10, 1, 11, 1, 0, 0, 1, 3'b101, 32'h400, "s6_raw");
        cyc(1, 0, 0, 0, 10, 1, 11, 1, 0, 1, 0, 3'b000, 32'h0, "s6_fire");
        drain();

        // x0 and unit=none are never tracked; unused sources and invalid slots never stall
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'b000, 32'h0, "s7_mul_x0");
        cyc(1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 3'b000, 32'h0, "s7_read_x0");
        cyc(1, 3, 0, 0, 0, 0, 12, 1, 0, 1, 0, 3'b000, 32'h0, "s7_none");
        cyc(1, 0, 12, 1, 0, 0, 13, 1, 0, 1, 0, 3'b000, 32'h0, "s7_after_none");
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 3'b000, 32'h0, "s7_mul");
        cyc(1, 0, 5, 0, 0, 0, 6, 1, 0, 1, 0, 3'b000, 32'h20, "s7_nouse");
        cyc(0, 0, 5, 1, 5, 1, 6, 1, 0, 0, 0, 3'b000, 32'h20, "s7_invalid");
        drain();

        // Asynchronous reset mid-countdown
        cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 3'b000, 32'h0, "s8_mul");
        cyc(1, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 3'b001, 32'h20, "s8_raw");
        drive(1, 0, 5, 1, 0, 0, 6, 1, 0);
        #2 rsn = 1'b0;
        push(1, 0, 3'b000, 32'h0);
        check("s8_in_reset");
        rsn = 1'b1;
        push(1, 0, 3'b000, 32'h0);
        check("s8_release_fire");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0, "s8_after");

        total++;
        assert (q.size() == 0) else begin
            bad++; $error("FAIL leftover obs=%0d exp=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
